// File: rtl/doa_pkg.sv
// Shared types and default sizing for the direction-of-arrival peak search.
package doa_pkg;

    localparam int POW_WIDTH   = 54;
    localparam int N_AVG       = 16;
    localparam int N_ANGLES    = 181;
    localparam int ANGLE_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CMP   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/doa_peak_search_peak_tracker.sv
// Running-maximum register: keeps the largest value seen and the index it came from.
module peak_tracker #(
    parameter int VALUE_WIDTH = 58,
    parameter int INDEX_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   en,
    input  logic [VALUE_WIDTH-1:0] value,
    input  logic [INDEX_WIDTH-1:0] index,
    output logic [VALUE_WIDTH-1:0] max_value,
    output logic [INDEX_WIDTH-1:0] max_index
);

    // Index 0 always loads so a sweep never compares against a stale maximum;
    // strict greater-than keeps the lower index on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_value <= '0;
            max_index <= '0;
        end else if (clear) begin
            max_value <= '0;
            max_index <= '0;
        end else if (en && ((value > max_value) || (index == '0))) begin
            max_value <= value;
            max_index <= index;
        end
    end

endmodule

// File: rtl/doa_peak_search.sv
// Sweeps steering angles, averages N_AVG beam-power samples per angle and reports the strongest angle.
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | accepting samples for angle_idx
// CMP   | compare accumulated power with running maximum, advance angle
// DONE  | publish result, pulse done
module doa_peak_search
    import doa_pkg::*;
#(
    parameter int POW_WIDTH   = doa_pkg::POW_WIDTH,
    parameter int N_AVG       = doa_pkg::N_AVG,
    parameter int N_ANGLES    = doa_pkg::N_ANGLES,
    parameter int ANGLE_WIDTH = doa_pkg::ANGLE_WIDTH,
    localparam int ACC_WIDTH  = POW_WIDTH + $clog2(N_AVG)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   pow_valid,
    input  logic [POW_WIDTH-1:0]   pow_in,
    output logic                   pow_ready,
    output logic [ANGLE_WIDTH-1:0] angle_idx,
    output logic                   busy,
    output logic                   done,
    output logic [ANGLE_WIDTH-1:0] peak_angle,
    output logic [ACC_WIDTH-1:0]   peak_power
);

    localparam int SCNT_WIDTH = ($clog2(N_AVG) > 0) ? $clog2(N_AVG) : 1;
    localparam logic [SCNT_WIDTH-1:0]  SCNT_LOAD  = SCNT_WIDTH'(N_AVG - 1);
    localparam logic [ANGLE_WIDTH-1:0] LAST_ANGLE = ANGLE_WIDTH'(N_ANGLES - 1);

    state_t                 state;
    logic [SCNT_WIDTH-1:0]  sample_cnt;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   max_value;
    logic [ANGLE_WIDTH-1:0] max_index;
    logic                   accept;

    assign accept = (state == ACCUM) && pow_valid && pow_ready;

    peak_tracker #(
        .VALUE_WIDTH(ACC_WIDTH),
        .INDEX_WIDTH(ANGLE_WIDTH)
    ) u_peak_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     ((state == IDLE) && start),
        .en        (state == CMP),
        .value     (acc),
        .index     (angle_idx),
        .max_value (max_value),
        .max_index (max_index)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sample_cnt <= '0;
            acc        <= '0;
            angle_idx  <= '0;
            pow_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            peak_angle <= '0;
            peak_power <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ACCUM;
                        angle_idx  <= '0;
                        sample_cnt <= SCNT_LOAD;
                        acc        <= '0;
                        pow_ready  <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc + ACC_WIDTH'(pow_in);
                        // sample_cnt counts down; zero marks the last sample of this angle
                        if (sample_cnt == '0) begin
                            state     <= CMP;
                            pow_ready <= 1'b0;
                        end else begin
                            sample_cnt <= sample_cnt - 1'b1;
                        end
                    end
                end
                CMP: begin
                    if (angle_idx == LAST_ANGLE) begin
                        state <= DONE;
                    end else begin
                        state      <= ACCUM;
                        angle_idx  <= angle_idx + 1'b1;
                        sample_cnt <= SCNT_LOAD;
                        acc        <= '0;
                        pow_ready  <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    peak_angle <= max_index;
                    peak_power <= max_value;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_doa_peak_search.sv
// Scoreboard bench for doa_peak_search: expected peaks queued at sweep start, checked on done.
module tb_doa_peak_search;

    localparam int PW   = 54;
    localparam int NAVG = 4;
    localparam int NANG = 8;
    localparam int AW   = 8;
    localparam int ACCW = PW + 2;
    localparam int LAT  = NANG * (NAVG + 1) + 1;

    typedef struct {
        logic [AW-1:0]   angle;
        logic [ACCW-1:0] power;
    } res_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            pow_valid;
    logic [PW-1:0]   pow_in;
    logic            pow_ready;
    logic [AW-1:0]   angle_idx;
    logic            busy;
    logic            done;
    logic [AW-1:0]   peak_angle;
    logic [ACCW-1:0] peak_power;

    res_t          exp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            done_cnt = 0;
    bit            done_seen = 0;
    int            acc_cnt[NANG];
    logic [PW-1:0] pat[NANG];
    bit            have_prev = 0;
    logic [AW-1:0] prev_angle;

    doa_peak_search #(
        .POW_WIDTH  (PW),
        .N_AVG      (NAVG),
        .N_ANGLES   (NANG),
        .ANGLE_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pow_valid (pow_valid),
        .pow_in    (pow_in),
        .pow_ready (pow_ready),
        .angle_idx (angle_idx),
        .busy      (busy),
        .done      (done),
        .peak_angle(peak_angle),
        .peak_power(peak_power)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic res_t model_peak();
        res_t r;
        logic [ACCW-1:0] p;
        r.angle = '0;
        r.power = '0;
        for (int a = 0; a < NANG; a++) begin
            p = ACCW'(pat[a]) * ACCW'(NAVG);
            if (a == 0 || p > r.power) begin
                r.power = p;
                r.angle = AW'(a);
            end
        end
        return r;
    endfunction

    task automatic fill_pat(input logic [PW-1:0] base);
        for (int a = 0; a < NANG; a++) pat[a] = base;
    endtask

    always @(negedge clk) begin : monitor
        res_t e;
        if (rst_n) begin
            if (pow_valid && pow_ready && angle_idx < NANG) acc_cnt[angle_idx]++;
            if (done) begin
                done_cnt++;
                done_seen = 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("peak_angle", 64'(peak_angle), 64'(e.angle));
                    check("peak_power", 64'(peak_power), 64'(e.power));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pow_ready"}, 64'(pow_ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_angle_idx"}, 64'(angle_idx), 64'd0);
        check({tag, "_peak_angle"}, 64'(peak_angle), 64'd0);
        check({tag, "_peak_power"}, 64'(peak_power), 64'd0);
    endtask

    task automatic run_sweep(input int gap_max, input int restart_at, input int abort_angle,
                             input bit check_lat);
        int   cyc;
        int   gap;
        int   lat;
        int   d0;
        res_t x;
        x = model_peak();
        if (abort_angle < 0) exp_q.push_back(x);
        for (int a = 0; a < NANG; a++) acc_cnt[a] = 0;
        done_seen = 0;
        d0 = done_cnt;
        gap = 0;
        lat = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        check("busy_after_start", 64'(busy), 64'd1);
        while (!done_seen && cyc < 3000) begin
            start = (cyc == restart_at);
            if (have_prev && cyc == 20) check("peak_hold", 64'(peak_angle), 64'(prev_angle));
            if (gap > 0) begin
                pow_valid = 1'b0;
                gap--;
            end else begin
                pow_valid = 1'b1;
                pow_in = (angle_idx < NANG) ? pat[angle_idx] : '0;
            end
            @(negedge clk);
            if (done && lat < 0) lat = cyc;
            if (abort_angle >= 0 && angle_idx == AW'(abort_angle)) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                pow_valid = 1'b0;
                start = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                have_prev = 0;
                break;
            end
            if (pow_valid && pow_ready && gap_max > 0) gap = $urandom_range(0, gap_max);
            @(posedge clk);
            cyc++;
            #1;
        end
        pow_valid = 1'b0;
        start = 1'b0;
        if (abort_angle < 0) begin
            if (!done_seen) check("done_timeout", 64'd0, 64'd1);
            if (check_lat) check("latency", 64'(lat), 64'(LAT));
            for (int a = 0; a < NANG; a++)
                check($sformatf("accepted_a%0d", a), 64'(acc_cnt[a]), 64'(NAVG));
            check("busy_idle", 64'(busy), 64'd0);
            prev_angle = x.angle;
            have_prev = 1;
        end
        repeat (60) @(posedge clk);
        #1;
        check("done_count", 64'(done_cnt - d0), (abort_angle < 0) ? 64'd1 : 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        pow_valid = 1'b0;
        pow_in = '0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // spike at angle 5, no stalls, latency measured
        fill_pat(PW'(10)); pat[5] = PW'(100);
        run_sweep(0, -1, -1, 1'b1);

        // flat power: lowest angle wins
        fill_pat(PW'(7));
        run_sweep(0, -1, -1, 1'b1);

        // tie between two raised angles
        fill_pat(PW'(20)); pat[3] = PW'(60); pat[6] = PW'(60);
        run_sweep(0, -1, -1, 1'b1);

        // random stalls, peak at the last angle
        fill_pat(PW'(10)); pat[7] = PW'(50);
        run_sweep(5, -1, -1, 1'b0);

        // start pulsed mid-sweep must be ignored
        fill_pat(PW'(11)); pat[2] = PW'(30);
        run_sweep(0, 10, -1, 1'b1);

        // reset at angle 3 abandons the sweep
        fill_pat(PW'(10)); pat[6] = PW'(80);
        run_sweep(0, -1, 3, 1'b0);
        check("busy_after_abort", 64'(busy), 64'd0);

        fill_pat(PW'(10)); pat[2] = PW'(90);
        run_sweep(0, -1, -1, 1'b1);

        // full-scale samples must not wrap
        fill_pat({PW{1'b1}});
        run_sweep(2, -1, -1, 1'b0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
